// File: rtl/soc_mem_if.sv
// Processor-side memory bus: byte address, read strobe, byte-masked write and busy handshake.
interface soc_mem_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rbusy;
  logic        mem_wbusy;

  modport master (
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/soc_mem_responder.sv
// Memory-side responder: RAM plus IO page (LEDS, CYCLES, SCRATCH, ID) with programmable wait states.
// Define CYCLE_COUNTER_EN to build the free-running CYCLES counter; otherwise IO register 1 reads 0.
//
// state  | meaning
// S_IDLE | ready to accept; with WAIT_STATES=0 every access completes here
// S_WAIT | latched access in flight, cnt_q cycles remain before completion
module soc_mem_responder #(
  parameter int unsigned WORDS       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned IO_BIT      = 22
) (
  input  logic         clk,
  input  logic         resetn,
  soc_mem_if.slave     bus,
  output logic [4:0]   leds
);

  localparam int unsigned AW      = $clog2(WORDS);
  localparam logic [31:0] ID_WORD = 32'h52563332;
  localparam bit          ZERO_WS = (WAIT_STATES == 0);
  localparam logic [2:0]  WS_LOAD = ZERO_WS ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q, scratch_q, cycles;
  logic [3:0]  wmask_q;
  logic        rd_q;
  logic [2:0]  cnt_q;
  logic [4:0]  leds_q;
  logic [31:0] ram [WORDS];

  logic        accept, done, c_rd, c_wr, c_io;
  logic [31:0] c_addr, c_wdata, io_word, rd_word;
  logic [3:0]  c_wmask;
  logic [AW-1:0] c_idx;
  logic        unused_addr;

  assign accept = (state_q == S_IDLE) && (bus.mem_rstrb || (|bus.mem_wmask));

  // Zero wait states complete on the live bus; otherwise from the latched copy.
  assign c_addr  = ZERO_WS ? bus.mem_addr  : addr_q;
  assign c_wdata = ZERO_WS ? bus.mem_wdata : wdata_q;
  assign c_wmask = ZERO_WS ? bus.mem_wmask : wmask_q;
  assign c_rd    = ZERO_WS ? bus.mem_rstrb : rd_q;
  assign c_wr    = |c_wmask;
  assign done    = ZERO_WS ? accept : ((state_q == S_WAIT) && (cnt_q == 3'd0));
  assign c_io    = c_addr[IO_BIT];
  assign c_idx   = c_addr[AW+1:2];
  assign unused_addr = ^c_addr;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycles_q <= 32'h0;
    else         cycles_q <= cycles_q + 32'h1;
  end
  assign cycles = cycles_q;
`else
  assign cycles = 32'h0;
`endif

  always_comb begin
    io_word = 32'h0;
    case (c_addr[3:2])
      2'd0:    io_word = {27'h0, leds_q};
      2'd1:    io_word = cycles;
      2'd2:    io_word = scratch_q;
      default: io_word = ID_WORD;
    endcase
  end

  assign rd_word = c_io ? io_word : ram[c_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (accept && !ZERO_WS) state_n = S_WAIT;
      S_WAIT:  if (cnt_q == 3'd0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rbusy = (state_q == S_WAIT) && rd_q;
    bus.mem_wbusy = (state_q == S_WAIT) && (|wmask_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wmask_q   <= 4'h0;
      rd_q      <= 1'b0;
      cnt_q     <= 3'd0;
      rdata_q   <= 32'h0;
      leds_q    <= 5'h0;
      scratch_q <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        wmask_q <= bus.mem_wmask;
        rd_q    <= bus.mem_rstrb;
        cnt_q   <= WS_LOAD;
      end else if ((state_q == S_WAIT) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (done && c_rd) rdata_q <= rd_word;
      if (done && c_wr && c_io) begin
        case (c_addr[3:2])
          2'd0: if (c_wmask[0]) leds_q <= c_wdata[4:0];
          2'd2: for (int b = 0; b < 4; b++)
                  if (c_wmask[b]) scratch_q[8*b +: 8] <= c_wdata[8*b +: 8];
          default: ;
        endcase
      end
    end
  end

  // RAM is not reset; the read above samples it at the same edge, so a combined access sees old data.
  always_ff @(posedge clk) begin
    if (done && c_wr && !c_io)
      for (int b = 0; b < 4; b++)
        if (c_wmask[b]) ram[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
  end

  assign bus.mem_rdata = rdata_q;
  assign leds          = leds_q;

endmodule

// File: tb/tb_soc_mem_responder.sv
// Scoreboard bench: a zero-wait-state and a three-wait-state responder driven by directed accesses.
module tb_soc_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic [4:0] leds0, leds1;

  soc_mem_if bus0();
  soc_mem_if bus1();

  soc_mem_responder #(.WORDS(256), .WAIT_STATES(0), .IO_BIT(22)) dut0 (
    .clk(clk), .resetn(rst0_n), .bus(bus0.slave), .leds(leds0)
  );
  soc_mem_responder #(.WORDS(256), .WAIT_STATES(3), .IO_BIT(22)) dut1 (
    .clk(clk), .resetn(rst1_n), .bus(bus1.slave), .leds(leds1)
  );

`ifdef CYCLE_COUNTER_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  typedef struct packed {
    logic        care;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  logic r0_d = 1'b0;
  logic rb1_prev = 1'b0;
  logic busy0_seen = 1'b0;
  logic [31:0] cyc_a, cyc_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero wait states: read data is due one edge after the strobe.
  always @(posedge clk) r0_d <= bus0.mem_rstrb && rst0_n;

  always @(negedge clk) begin
    if (r0_d && rst0_n) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected: got %h expected no read", bus0.mem_rdata);
      end else begin
        e0 = q0.pop_front();
        if (e0.care) chk("rd0_data", bus0.mem_rdata, e0.data);
      end
    end
    if (bus0.mem_rbusy || bus0.mem_wbusy) busy0_seen = 1'b1;
  end

  // Wait states: read data is due when rbusy falls.
  always @(negedge clk) begin
    if (rst1_n && rb1_prev && !bus1.mem_rbusy) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected: got %h expected no read", bus1.mem_rdata);
      end else begin
        e1 = q1.pop_front();
        if (e1.care) chk("rd1_data", bus1.mem_rdata, e1.data);
      end
    end
    rb1_prev = bus1.mem_rbusy;
  end

  task automatic acc0(input logic [31:0] a, input logic rd, input logic [3:0] m,
                      input logic [31:0] d, input logic care, input logic [31:0] exp);
    bus0.mem_addr = a; bus0.mem_rstrb = rd; bus0.mem_wmask = m; bus0.mem_wdata = d;
    if (rd) q0.push_back({care, exp});
    tick();
    bus0.mem_rstrb = 1'b0; bus0.mem_wmask = 4'h0;
  endtask

  task automatic acc1(input logic [31:0] a, input logic rd, input logic [3:0] m,
                      input logic [31:0] d, input logic [31:0] exp);
    bus1.mem_addr = a; bus1.mem_rstrb = rd; bus1.mem_wmask = m; bus1.mem_wdata = d;
    if (rd) q1.push_back({1'b1, exp});
    tick();
    bus1.mem_rstrb = 1'b0; bus1.mem_wmask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk("rbusy1_active", {31'h0, bus1.mem_rbusy}, {31'h0, rd});
      chk("wbusy1_active", {31'h0, bus1.mem_wbusy}, {31'h0, |m});
      tick();
    end
    chk("rbusy1_done", {31'h0, bus1.mem_rbusy}, 32'h0);
    chk("wbusy1_done", {31'h0, bus1.mem_wbusy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus0.mem_addr = 0; bus0.mem_rstrb = 0; bus0.mem_wmask = 0; bus0.mem_wdata = 0;
    bus1.mem_addr = 0; bus1.mem_rstrb = 0; bus1.mem_wmask = 0; bus1.mem_wdata = 0;
    rst0_n = 1'b1; rst1_n = 1'b1;
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    tick(); tick();
    chk("rst_rdata0", bus0.mem_rdata, 32'h0);
    chk("rst_busy0", {30'h0, bus0.mem_rbusy, bus0.mem_wbusy}, 32'h0);
    chk("rst_leds0", {27'h0, leds0}, 32'h0);
    chk("rst_rdata1", bus1.mem_rdata, 32'h0);
    chk("rst_busy1", {30'h0, bus1.mem_rbusy, bus1.mem_wbusy}, 32'h0);
    chk("rst_leds1", {27'h0, leds1}, 32'h0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    tick();

    // Zero wait states
    acc0(32'h10, 0, 4'hF, 32'hDEADBEEF, 0, 0);
    acc0(32'h10, 1, 4'h0, 0, 1, 32'hDEADBEEF);
    acc0(32'h10, 0, 4'h1, 32'h000000AA, 0, 0);
    acc0(32'h10, 1, 4'h0, 0, 1, 32'hDEADBEAA);
    acc0(32'h400000, 0, 4'hF, 32'h3F, 0, 0);
    chk("leds_write", {27'h0, leds0}, 32'h1F);
    acc0(32'h400000, 1, 4'h0, 0, 1, 32'h1F);
    acc0(32'h40000C, 1, 4'h0, 0, 1, 32'h52563332);
    acc0(32'h40000C, 0, 4'hF, 32'hFFFFFFFF, 0, 0);
    acc0(32'h40000C, 1, 4'h0, 0, 1, 32'h52563332);
    acc0(32'h400008, 0, 4'hF, 32'h12345678, 0, 0);
    acc0(32'h400008, 0, 4'h4, 32'h00AB0000, 0, 0);
    acc0(32'h400008, 1, 4'h0, 0, 1, 32'h12AB5678);
    acc0(32'h20, 0, 4'hF, 32'h11111111, 0, 0);
    acc0(32'h20, 1, 4'hF, 32'h22222222, 1, 32'h11111111);
    acc0(32'h20, 1, 4'h0, 0, 1, 32'h22222222);
    acc0(32'h400, 0, 4'hF, 32'hCAFEF00D, 0, 0);
    acc0(32'h0, 1, 4'h0, 0, 1, 32'hCAFEF00D);
    acc0(32'h400004, 1, 4'h0, 0, !CC_EN, 32'h0);
    cyc_a = bus0.mem_rdata;
    repeat (9) tick();
    acc0(32'h400004, 1, 4'h0, 0, !CC_EN, 32'h0);
    cyc_b = bus0.mem_rdata;
    chk("cycles_delta", cyc_b - cyc_a, CC_EN ? 32'd10 : 32'd0);

    // Three wait states
    acc1(32'h10, 0, 4'hF, 32'h55AA55AA, 0);
    bus1.mem_addr = 32'h10; bus1.mem_rstrb = 1'b1;
    q1.push_back({1'b1, 32'h55AA55AA});
    tick();
    bus1.mem_rstrb = 1'b0;
    chk("t4_rbusy_t1", {31'h0, bus1.mem_rbusy}, 32'h1);
    tick();
    chk("t4_rbusy_t2", {31'h0, bus1.mem_rbusy}, 32'h1);
    bus1.mem_addr = 32'h20; bus1.mem_rstrb = 1'b1;
    tick();
    bus1.mem_rstrb = 1'b0;
    chk("t4_rbusy_t3", {31'h0, bus1.mem_rbusy}, 32'h1);
    tick();
    chk("t4_rbusy_t4", {31'h0, bus1.mem_rbusy}, 32'h0);
    chk("t4_rdata_t4", bus1.mem_rdata, 32'h55AA55AA);
    tick();
    chk("t4_ignored_t5", {31'h0, bus1.mem_rbusy}, 32'h0);

    acc1(32'h10, 0, 4'hC, 32'hFFFF0000, 0);
    acc1(32'h10, 1, 4'h0, 0, 32'hFFFF55AA);
    acc1(32'h20, 0, 4'hF, 32'h11111111, 0);
    acc1(32'h20, 1, 4'hF, 32'h22222222, 32'h11111111);
    acc1(32'h20, 1, 4'h0, 0, 32'h22222222);

    acc1(32'h24, 0, 4'hF, 32'h11223344, 0);
    bus1.mem_addr = 32'h24; bus1.mem_wmask = 4'hF; bus1.mem_wdata = 32'h99999999;
    tick();
    bus1.mem_wmask = 4'h0;
    chk("t6_wbusy_t1", {31'h0, bus1.mem_wbusy}, 32'h1);
    tick();
    rst1_n = 1'b0;
    #1;
    chk("t6_rst_busy", {30'h0, bus1.mem_rbusy, bus1.mem_wbusy}, 32'h0);
    chk("t6_rst_rdata", bus1.mem_rdata, 32'h0);
    tick();
    rst1_n = 1'b1;
    tick();
    acc1(32'h24, 1, 4'h0, 0, 32'h11223344);

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    chk("busy0_never", {31'h0, busy0_seen}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
